// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter: I-cache and D-cache share one main-memory port.
// Round-robin on ties, no pre-emption, registered memory strobes and read data.
module mem_bus_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_read_i,
   input  logic [ADDR_W-1:0] i_address_i,
   output logic [DATA_W-1:0] i_readdata_o,
   output logic              i_busywait_o,
   input  logic              d_read_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_address_i,
   input  logic [DATA_W-1:0] d_writedata_i,
   output logic [DATA_W-1:0] d_readdata_o,
   output logic              d_busywait_o,
   output logic              m_read_o,
   output logic              m_write_o,
   output logic [ADDR_W-1:0] m_address_o,
   output logic [DATA_W-1:0] m_writedata_o,
   input  logic [DATA_W-1:0] m_readdata_i,
   input  logic              m_busywait_i
);

   // state    | meaning
   // S_IDLE   | no transfer, waiting for a request
   // S_I_BUSY | I transfer on the memory port
   // S_D_BUSY | D transfer on the memory port
   // S_I_DONE | I transfer finished, I_BUSYWAIT low for one cycle
   // S_D_DONE | D transfer finished, D_BUSYWAIT low for one cycle
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_I_BUSY = 3'd1;
   localparam logic [2:0] S_D_BUSY = 3'd2;
   localparam logic [2:0] S_I_DONE = 3'd3;
   localparam logic [2:0] S_D_DONE = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              first_q, first_d;
   logic              last_d_q, last_d_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic req_i, req_d, grant_i, grant_d;

   assign req_i   = i_read_i;
   assign req_d   = d_read_i | d_write_i;
   assign grant_d = req_d & (~req_i | ~last_d_q);
   assign grant_i = req_i & ~grant_d;

   always_comb begin
      state_d   = state_q;
      first_d   = first_q;
      last_d_d  = last_d_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         S_IDLE, S_I_DONE, S_D_DONE: begin
            if (grant_d) begin
               state_d   = S_D_BUSY;
               first_d   = 1'b1;
               last_d_d  = 1'b1;
               m_addr_d  = d_address_i;
               m_wdata_d = d_writedata_i;
               m_write_d = d_write_i;
               m_read_d  = ~d_write_i;
            end else if (grant_i) begin
               state_d   = S_I_BUSY;
               first_d   = 1'b1;
               last_d_d  = 1'b0;
               m_addr_d  = i_address_i;
               m_write_d = 1'b0;
               m_read_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_I_BUSY, S_D_BUSY: begin
            // Memory may not raise BUSYWAIT until it has seen the strobe, so the first cycle never completes.
            if (first_q) begin
               first_d = 1'b0;
            end else if (!m_busywait_i) begin
               if (m_read_q && state_q == S_I_BUSY) i_rdata_d = m_readdata_i;
               if (m_read_q && state_q == S_D_BUSY) d_rdata_d = m_readdata_i;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               state_d   = (state_q == S_I_BUSY) ? S_I_DONE : S_D_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         first_q   <= 1'b0;
         last_d_q  <= 1'b0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         last_d_q  <= last_d_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign i_busywait_o  = req_i & (state_q != S_I_DONE);
   assign d_busywait_o  = req_d & (state_q != S_D_DONE);
   assign m_read_o      = m_read_q;
   assign m_write_o     = m_write_q;
   assign m_address_o   = m_addr_q;
   assign m_writedata_o = m_wdata_q;
   assign i_readdata_o  = i_rdata_q;
   assign d_readdata_o  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a simple latency-programmable memory model.
module tb_mem_bus_arbiter;
   localparam int AW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_read = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_bw;
   logic          d_read = 1'b0;
   logic          d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_bw;
   logic          m_read, m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic          m_busy;

   int n_cmp = 0;
   int n_err = 0;
   int mem_lat = 0;
   int cnt;
   int n;
   logic [DW-1:0] mem [64];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .i_read_i(i_read), .i_address_i(i_addr), .i_readdata_o(i_rdata), .i_busywait_o(i_bw),
      .d_read_i(d_read), .d_write_i(d_write), .d_address_i(d_addr), .d_writedata_i(d_wdata),
      .d_readdata_o(d_rdata), .d_busywait_o(d_bw),
      .m_read_o(m_read), .m_write_o(m_write), .m_address_o(m_addr), .m_writedata_o(m_wdata),
      .m_readdata_i(m_rdata), .m_busywait_i(m_busy)
   );

   // Memory: busy for mem_lat cycles after the strobe appears, contents preloaded while reset is high.
   assign m_busy  = (m_read | m_write) && (cnt != 0);
   assign m_rdata = mem[m_addr];

   always @(posedge clk) begin
      if (!(m_read | m_write)) cnt <= mem_lat;
      else if (cnt != 0) cnt <= cnt - 1;
      if (rst) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'hA000_0000 | k;
         mem[5] <= 32'hDEAD_BEEF;
      end else if (m_write && !m_busy) begin
         mem[m_addr] <= m_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_low(input bit side_d, output int cycles);
      cycles = 0;
      while ((side_d ? d_bw : i_bw) && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      // reset state, BUSYWAIT follows request during reset
      #12;
      chk("rst_m_read", m_read, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      d_read = 1'b1;
      #1;
      chk("rst_d_bw_follows", d_bw, 1);
      chk("rst_i_bw_idle", i_bw, 0);
      d_read = 1'b0;
      #9 rst = 1'b0;
      tick();

      // test 1: single I read, latency 5
      mem_lat = 5;
      i_read = 1'b1; i_addr = 6'h05;
      #1;
      chk("t1_i_bw_rise", i_bw, 1);
      chk("t1_no_strobe_yet", m_read, 0);
      tick();
      chk("t1_m_read", m_read, 1);
      chk("t1_m_write", m_write, 0);
      chk("t1_m_addr", m_addr, 6'h05);
      wait_low(1'b0, n);
      chk("t1_latency", n, 6);
      chk("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
      chk("t1_d_rdata_untouched", d_rdata, 0);
      chk("t1_strobe_dropped", m_read, 0);
      chk("t1_d_bw", d_bw, 0);
      i_read = 1'b0;
      tick();
      chk("t1_idle_m_read", m_read, 0);
      chk("t1_idle_i_bw", i_bw, 0);

      // test 2: simultaneous requests after reset, D wins first tie
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      mem_lat = 2;
      i_read = 1'b1; i_addr = 6'h07;
      d_read = 1'b1; d_addr = 6'h09;
      tick();
      chk("t2_first_grant_d", m_addr, 6'h09);
      chk("t2_m_read", m_read, 1);
      n = 0;
      while (d_bw && n < 40) begin
         chk("t2_i_bw_held", i_bw, 1);
         tick();
         n++;
      end
      chk("t2_d_latency", n, 3);
      chk("t2_d_rdata", d_rdata, 32'hA000_0009);
      chk("t2_i_bw_in_d_done", i_bw, 1);
      d_read = 1'b0;
      tick();
      chk("t2_i_granted_no_gap", m_read, 1);
      chk("t2_i_addr", m_addr, 6'h07);
      wait_low(1'b0, n);
      chk("t2_i_latency", n, 3);
      chk("t2_i_rdata", i_rdata, 32'hA000_0007);
      i_read = 1'b0;
      tick();

      // test 3: both held high, grants alternate D, I, D, ...
      mem_lat = 0;
      i_read = 1'b1; i_addr = 6'h11;
      d_read = 1'b1; d_addr = 6'h22;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_rr_order", m_addr, (k % 2 == 0) ? 6'h22 : 6'h11);
         wait_low((k % 2) == 0, n);
         chk("t3_min_latency", n, 2);
         chk("t3_loser_stalled", (k % 2 == 0) ? i_bw : d_bw, 1);
      end
      i_read = 1'b0; d_read = 1'b0;
      tick();
      chk("t3_i_rdata", i_rdata, 32'hA000_0011);
      chk("t3_d_rdata", d_rdata, 32'hA000_0022);
      chk("t3_idle", m_read, 0);

      // test 4: D write
      mem_lat = 3;
      d_write = 1'b1; d_addr = 6'h2A; d_wdata = 32'h1234_5678;
      tick();
      chk("t4_m_write", m_write, 1);
      chk("t4_m_read", m_read, 0);
      chk("t4_m_addr", m_addr, 6'h2A);
      chk("t4_m_wdata", m_wdata, 32'h1234_5678);
      d_wdata = 32'h0BAD_0BAD;
      tick();
      chk("t4_wdata_held", m_wdata, 32'h1234_5678);
      wait_low(1'b1, n);
      chk("t4_latency", n, 3);
      chk("t4_d_rdata_kept", d_rdata, 32'hA000_0022);
      chk("t4_mem_written", mem[6'h2A], 32'h1234_5678);
      d_write = 1'b0;
      tick();

      // test 5: read and write together is a write
      mem_lat = 1;
      d_read = 1'b1; d_write = 1'b1; d_addr = 6'h30; d_wdata = 32'hCAFE_F00D;
      tick();
      chk("t5_m_write", m_write, 1);
      chk("t5_m_read", m_read, 0);
      wait_low(1'b1, n);
      chk("t5_latency", n, 2);
      chk("t5_d_rdata_kept", d_rdata, 32'hA000_0022);
      d_read = 1'b0; d_write = 1'b0;
      tick();

      // test 6: reset in the middle of a D read
      mem_lat = 8;
      d_read = 1'b1; d_addr = 6'h15;
      tick();
      chk("t6_m_read", m_read, 1);
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_async_m_read", m_read, 0);
      chk("t6_async_m_addr", m_addr, 0);
      chk("t6_async_d_rdata", d_rdata, 0);
      chk("t6_d_bw_follows", d_bw, 1);
      mem_lat = 1;
      tick();
      #2 rst = 1'b0;
      tick();
      chk("t6_regrant", m_read, 1);
      chk("t6_regrant_addr", m_addr, 6'h15);
      wait_low(1'b1, n);
      chk("t6_latency", n, 2);
      chk("t6_d_rdata", d_rdata, 32'hA000_0015);
      d_read = 1'b0;
      tick();
      chk("t6_idle", m_read, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
